// File: rtl/cpu_pkg.sv
// Shared CPU types for the decode stage: ALU/branch encodings, control bundle,
// RV32I opcode/funct constants and small decode helpers.
package cpu_pkg;

  localparam int unsigned ILEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } t_alu_op;

  typedef enum logic [3:0] {
    BR_NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU, BR_JAL, BR_JALR
  } t_br_type;

  typedef struct packed {
    t_alu_op    alu_op;
    logic       sel_alu_pc;   // ALU operand A = pc instead of rs1
    logic       sel_alu_imm;  // ALU operand B = imm instead of rs2
    logic       reg_wr_en;
    logic       mem_rd_en;
    logic       mem_wr_en;
    logic [3:0] mem_byt_en;   // unshifted; alignment happens in memory stage
    logic       mem_unsigned;
    logic       sel_dmem_wb;
    logic       sel_pc4_wb;   // write back pc+4 (jumps)
    t_br_type   br_type;
  } t_ctrl;

  localparam t_ctrl CTRL_NOP = '{
    alu_op: ALU_ADD, sel_alu_pc: 1'b0, sel_alu_imm: 1'b0, reg_wr_en: 1'b0,
    mem_rd_en: 1'b0, mem_wr_en: 1'b0, mem_byt_en: 4'b0000, mem_unsigned: 1'b0,
    sel_dmem_wb: 1'b0, sel_pc4_wb: 1'b0, br_type: BR_NONE
  };

  // Base integer ALU op from funct3; alt selects SUB/SRA
  function automatic t_alu_op alu_base_op(input logic [2:0] f3, input logic alt);
    t_alu_op op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

  // M-extension op from funct3
  function automatic t_alu_op alu_md_op(input logic [2:0] f3);
    t_alu_op op;
    case (f3)
      3'b000:  op = ALU_MUL;
      3'b001:  op = ALU_MULH;
      3'b010:  op = ALU_MULHSU;
      3'b011:  op = ALU_MULHU;
      3'b100:  op = ALU_DIV;
      3'b101:  op = ALU_DIVU;
      3'b110:  op = ALU_REM;
      default: op = ALU_REMU;
    endcase
    return op;
  endfunction

  // Byte enables from access size (funct3[1:0])
  function automatic logic [3:0] byt_en(input logic [1:0] sz);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001;
      2'b01:   be = 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: extracts and sign-extends the I/S/B/U/J immediate;
// zero for R-type and unknown opcodes.
module imm_gen
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] imm_c
);

  logic [31:0] imm32;

  // Format select by opcode
  always_comb begin
    imm32 = '0;
    case (instr[6:0])
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {instr[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: ;
    endcase
  end

  assign imm_c = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage with valid/ready handshake and 2-entry skid buffer.
// Optional: define DECODE_STAGE_RV32M_EN to decode the M extension (MUL..REMU).
module decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ILEN-1:0]       in_instr,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]       out_imm,
  output t_ctrl                 out_ctrl,
  output logic                  out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       imm;
    t_ctrl                 ctrl;
    logic                  illegal;
  } t_bundle;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} t_state;

  t_state          state, state_nxt;
  t_bundle         main_q, skid_q, dec_c;
  t_ctrl           ctrl_c;
  logic            illegal_c, wr_c;
  logic [XLEN-1:0] imm_c;
  logic            accept_c, drain_c, load_main_c, load_skid_c, skid_to_main_c;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .imm_c (imm_c)
  );

  // Instruction decode into control bundle plus legality check
  always_comb begin
    ctrl_c    = CTRL_NOP;
    illegal_c = 1'b0;
    wr_c      = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl_c.alu_op      = ALU_PASSB;
        ctrl_c.sel_alu_imm = 1'b1;
        wr_c               = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_c.sel_alu_pc  = 1'b1;
        ctrl_c.sel_alu_imm = 1'b1;
        wr_c               = 1'b1;
      end
      OPC_JAL: begin
        ctrl_c.sel_alu_pc  = 1'b1;
        ctrl_c.sel_alu_imm = 1'b1;
        ctrl_c.sel_pc4_wb  = 1'b1;
        ctrl_c.br_type     = BR_JAL;
        wr_c               = 1'b1;
      end
      OPC_JALR: begin
        ctrl_c.sel_alu_imm = 1'b1;
        ctrl_c.sel_pc4_wb  = 1'b1;
        ctrl_c.br_type     = BR_JALR;
        wr_c               = 1'b1;
        illegal_c          = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl_c.sel_alu_pc  = 1'b1;
        ctrl_c.sel_alu_imm = 1'b1;
        case (f3)
          F3_BEQ:  ctrl_c.br_type = BEQ;
          F3_BNE:  ctrl_c.br_type = BNE;
          F3_BLT:  ctrl_c.br_type = BLT;
          F3_BGE:  ctrl_c.br_type = BGE;
          F3_BLTU: ctrl_c.br_type = BLTU;
          F3_BGEU: ctrl_c.br_type = BGEU;
          default: illegal_c = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl_c.sel_alu_imm  = 1'b1;
        ctrl_c.mem_rd_en    = 1'b1;
        ctrl_c.mem_byt_en   = byt_en(f3[1:0]);
        ctrl_c.mem_unsigned = f3[2];
        ctrl_c.sel_dmem_wb  = 1'b1;
        wr_c                = 1'b1;
        illegal_c = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      end
      OPC_STORE: begin
        ctrl_c.sel_alu_imm = 1'b1;
        ctrl_c.mem_wr_en   = 1'b1;
        ctrl_c.mem_byt_en  = byt_en(f3[1:0]);
        illegal_c = !(f3 inside {F3_B, F3_H, F3_W});
      end
      OPC_OP_IMM: begin
        ctrl_c.alu_op      = alu_base_op(f3, (f3 == F3_SRL_SRA) && (f7 == F7_ALT));
        ctrl_c.sel_alu_imm = 1'b1;
        wr_c               = 1'b1;
        if (f3 == F3_SLL)
          illegal_c = (f7 != F7_BASE);
        else if (f3 == F3_SRL_SRA)
          illegal_c = (f7 != F7_BASE) && (f7 != F7_ALT);
      end
      OPC_OP: begin
        wr_c = 1'b1;
        if (f7 == F7_BASE)
          ctrl_c.alu_op = alu_base_op(f3, 1'b0);
        else if ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)))
          ctrl_c.alu_op = alu_base_op(f3, 1'b1);
`ifdef DECODE_STAGE_RV32M_EN
        else if (f7 == F7_MULDIV)
          ctrl_c.alu_op = alu_md_op(f3);
`endif
        else
          illegal_c = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11)
      illegal_c = 1'b1;
    ctrl_c.reg_wr_en = wr_c && (in_instr[11:7] != 5'd0);
    if (illegal_c)
      ctrl_c = CTRL_NOP;
  end

  assign dec_c = '{
    pc:      in_pc,
    rs1:     REG_ADDR_W'(in_instr[19:15]),
    rs2:     REG_ADDR_W'(in_instr[24:20]),
    rd:      REG_ADDR_W'(in_instr[11:7]),
    imm:     imm_c,
    ctrl:    ctrl_c,
    illegal: illegal_c
  };

  assign accept_c = in_valid && in_ready;
  assign drain_c  = out_valid && out_ready;

  // Handshake state register
  always_ff @(posedge Clk) begin
    if (Rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  // Next state and main/skid load controls
  always_comb begin
    state_nxt      = state;
    load_main_c    = 1'b0;
    load_skid_c    = 1'b0;
    skid_to_main_c = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept_c) begin
            state_nxt   = S_FULL;
            load_main_c = 1'b1;
          end
        end
        S_FULL: begin
          if (accept_c && drain_c) begin
            load_main_c = 1'b1;
          end else if (accept_c) begin
            state_nxt   = S_SKID;
            load_skid_c = 1'b1;
          end else if (drain_c) begin
            state_nxt = S_EMPTY;
          end
        end
        S_SKID: begin
          if (drain_c) begin
            state_nxt      = S_FULL;
            skid_to_main_c = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // Handshake flags and data registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      main_q      <= '0;
      main_q.ctrl <= CTRL_NOP;
      skid_q      <= '0;
      skid_q.ctrl <= CTRL_NOP;
    end else begin
      in_ready  <= (state_nxt != S_SKID);
      out_valid <= (state_nxt != S_EMPTY);
      if (load_main_c)         main_q <= dec_c;
      else if (skid_to_main_c) main_q <= skid_q;
      if (load_skid_c)         skid_q <= dec_c;
    end
  end

  assign out_pc      = main_q.pc;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd      = main_q.rd;
  assign out_imm     = main_q.imm;
  assign out_ctrl    = main_q.ctrl;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table plus streaming/skid and flush sequences.
module tb_decode_stage;
  import cpu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  t_ctrl       out_ctrl;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  decode_stage dut (
    .Clk(Clk), .Rst(Rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .out_illegal(out_illegal)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        ill;
    t_ctrl       ctrl;
  } t_vec;

  t_vec vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic t_ctrl mk(input t_alu_op a, input logic spc, input logic simm,
                               input logic wr, input logic mrd, input logic mwr,
                               input logic [3:0] be, input logic uns, input logic dwb,
                               input logic pc4, input t_br_type br);
    t_ctrl c;
    c.alu_op = a;        c.sel_alu_pc = spc;   c.sel_alu_imm = simm;
    c.reg_wr_en = wr;    c.mem_rd_en = mrd;    c.mem_wr_en = mwr;
    c.mem_byt_en = be;   c.mem_unsigned = uns; c.sel_dmem_wb = dwb;
    c.sel_pc4_wb = pc4;  c.br_type = br;
    return c;
  endfunction

  task automatic add(input string n, input logic [31:0] i, input int r1, input int r2,
                     input int rd, input logic [31:0] imm, input logic ill, input t_ctrl c);
    t_vec v;
    v.name = n; v.instr = i; v.rs1 = 5'(r1); v.rs2 = 5'(r2); v.rd = 5'(rd);
    v.imm = imm; v.ill = ill; v.ctrl = c;
    vq.push_back(v);
  endtask

  initial begin
    t_ctrl nopc;
    logic [31:0] sent[4];
    logic [31:0] got_q[$];
    logic [31:0] held_pc;
    logic        held;
    int          acc;

    nopc = mk(ALU_ADD, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, BR_NONE);
    add("add",    32'h002081B3, 1, 2, 3, 32'h0,        0, mk(ALU_ADD,   0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, BR_NONE));
    add("addi",   32'hFFF00293, 0, 31, 5, 32'hFFFFFFFF, 0, mk(ALU_ADD,  0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, BR_NONE));
    add("sw",     32'h0020A423, 1, 2, 8, 32'h8,        0, mk(ALU_ADD,   0, 1, 0, 0, 1, 4'b1111, 0, 0, 0, BR_NONE));
    add("bne",    32'hFE209EE3, 1, 2, 29, 32'hFFFFFFFC, 0, mk(ALU_ADD,  1, 1, 0, 0, 0, 4'b0000, 0, 0, 0, BNE));
    add("lui",    32'h123453B7, 8, 3, 7, 32'h12345000, 0, mk(ALU_PASSB, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, BR_NONE));
    add("lw",     32'hFF812303, 2, 24, 6, 32'hFFFFFFF8, 0, mk(ALU_ADD,  0, 1, 1, 1, 0, 4'b1111, 0, 1, 0, BR_NONE));
    add("lbu",    32'h0011C203, 3, 1, 4, 32'h1,        0, mk(ALU_ADD,   0, 1, 1, 1, 0, 4'b0001, 1, 1, 0, BR_NONE));
    add("srai",   32'h4032D293, 5, 3, 5, 32'h403,      0, mk(ALU_SRA,   0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, BR_NONE));
    add("slli7",  32'h40109093, 1, 1, 1, 32'h401,      1, nopc);
    add("sub",    32'h402081B3, 1, 2, 3, 32'h0,        0, mk(ALU_SUB,   0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, BR_NONE));
    add("jal",    32'h008000EF, 0, 8, 1, 32'h8,        0, mk(ALU_ADD,   1, 1, 1, 0, 0, 4'b0000, 0, 0, 1, BR_JAL));
    add("nop",    32'h00000013, 0, 0, 0, 32'h0,        0, mk(ALU_ADD,   0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, BR_NONE));
    add("zero",   32'h00000000, 0, 0, 0, 32'h0,        1, nopc);
    add("lowbit", 32'h002081B1, 1, 2, 3, 32'h0,        1, nopc);
    add("brf3",   32'h0020A063, 1, 2, 0, 32'h0,        1, nopc);
`ifdef DECODE_STAGE_RV32M_EN
    add("mul",    32'h022081B3, 1, 2, 3, 32'h0,        0, mk(ALU_MUL,   0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, BR_NONE));
`else
    add("mul",    32'h022081B3, 1, 2, 3, 32'h0,        1, nopc);
`endif

    // Reset (with flush also high: reset wins)
    Rst = 1'b1; flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;
    repeat (3) @(negedge Clk);
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.in_ready",  64'(in_ready), 64'(0));
    check("rst.ctrl",      64'(out_ctrl), 64'(nopc));
    check("rst.pc",        64'(out_pc), 64'(0));
    check("rst.imm",       64'(out_imm), 64'(0));
    Rst = 1'b0; flush = 1'b0;
    @(negedge Clk);
    check("post_rst.in_ready",  64'(in_ready), 64'(1));
    check("post_rst.out_valid", 64'(out_valid), 64'(0));

    // Decode table, streamed back to back with out_ready high
    out_ready = 1'b1;
    foreach (vq[i]) begin
      @(negedge Clk);
      in_valid = 1'b1; in_instr = vq[i].instr; in_pc = 32'h1000 + 32'(4 * i);
      @(posedge Clk); #1;
      check({vq[i].name, ".valid"}, 64'(out_valid), 64'(1));
      check({vq[i].name, ".pc"},    64'(out_pc), 64'(32'h1000 + 32'(4 * i)));
      check({vq[i].name, ".rs1"},   64'(out_rs1), 64'(vq[i].rs1));
      check({vq[i].name, ".rs2"},   64'(out_rs2), 64'(vq[i].rs2));
      check({vq[i].name, ".rd"},    64'(out_rd), 64'(vq[i].rd));
      check({vq[i].name, ".imm"},   64'(out_imm), 64'(vq[i].imm));
      check({vq[i].name, ".ill"},   64'(out_illegal), 64'(vq[i].ill));
      check({vq[i].name, ".ctrl"},  64'(out_ctrl), 64'(vq[i].ctrl));
    end
    @(negedge Clk);
    in_valid = 1'b0;
    repeat (2) @(negedge Clk);
    check("drain.out_valid", 64'(out_valid), 64'(0));

    // Stream 4 with out_ready low in cycles 1-3: skid fills, order kept
    for (int k = 0; k < 4; k++) sent[k] = 32'h2000 + 32'(4 * k);
    acc = 0; held = 1'b0; held_pc = '0;
    for (int cyc = 0; cyc < 30 && got_q.size() < 4; cyc++) begin
      @(negedge Clk);
      out_ready = !(cyc >= 1 && cyc <= 3);
      if (held && out_valid)
        check("stall.pc_stable", 64'(out_pc), 64'(held_pc));
      if (cyc == 2) begin
        check("stream.in_ready_low", 64'(in_ready), 64'(0));
        check("stream.accepts",      64'(acc), 64'(2));
      end
      if (acc < 4) begin
        in_valid = 1'b1;
        in_pc    = sent[acc];
        in_instr = 32'h00000013 | (32'(acc + 1) << 7);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        check($sformatf("stream.pc%0d", got_q.size()), 64'(out_pc), 64'(sent[got_q.size()]));
        check($sformatf("stream.rd%0d", got_q.size()), 64'(out_rd), 64'(got_q.size() + 1));
        got_q.push_back(out_pc);
      end
      held = out_valid && !out_ready;
      held_pc = out_pc;
      if (in_valid && in_ready) acc++;
    end
    check("stream.count", 64'(got_q.size()), 64'(4));
    @(negedge Clk);
    in_valid = 1'b0;
    repeat (2) @(negedge Clk);

    // Flush while SKID: both held entries and the flush-cycle input vanish
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h3000;
    @(negedge Clk);
    in_pc = 32'h3004;
    @(negedge Clk);
    check("flush.pre_skid", 64'(in_ready), 64'(0));
    flush = 1'b1; in_pc = 32'h3008;
    @(negedge Clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush.out_valid", 64'(out_valid), 64'(0));
    check("flush.in_ready",  64'(in_ready), 64'(1));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check($sformatf("flush.quiet%0d", k), 64'(out_valid), 64'(0));
    end
    in_valid = 1'b1; in_pc = 32'h300C;
    @(negedge Clk);
    in_valid = 1'b0;
    check("flush.next_valid", 64'(out_valid), 64'(1));
    check("flush.next_pc",    64'(out_pc), 64'(32'h300C));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
